// File: rtl/ascon_serial_host.sv
// Host driver for the bit-serial Ascon decryption core: serial load, start, wait, serial read.
// In: clk, rst (async low), key/nonce/ad/ct, start, core pt/tag/ready. Out: core xSO, pt, tag, busy/done/error.
module ascon_serial_host #(
  parameter int         K         = 128,
  parameter int         L         = 40,
  parameter int         Y         = 80,
  parameter int         MAX       = (K > L) ? ((K > Y) ? K : Y) : ((L > Y) ? L : Y),
  parameter int         START_CYC = 3,
  parameter int         GAP_CYC   = 2,
  parameter int         TIMEOUT   = 4096,
  parameter logic [9:0] SEED      = 10'h2A5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [K-1:0]   key,
  input  logic [127:0]   nonce,
  input  logic [L-1:0]   ad,
  input  logic [Y-1:0]   ct,
  input  logic           start,
  output logic [2:0]     keyxSO,
  output logic [2:0]     noncexSO,
  output logic [2:0]     associated_dataxSO,
  output logic [2:0]     cipher_textxSO,
  output logic           decryption_startxSO,
  output logic [6:0]     r_64xSO,
  output logic           r_128xSO,
  output logic           r_ptxSO,
  input  logic           plain_textxSI,
  input  logic           tagxSI,
  input  logic           decryption_readyxSI,
  output logic [Y-1:0]   pt,
  output logic [127:0]   tag,
  output logic           busy,
  output logic           done,
  output logic           error
);

  localparam int CW = $clog2(MAX + 1);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT, S_GAP, S_READ
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic accept, shift, done_d, err_set;

  logic [3:0][MAX-1:0] par;
  logic [3:0][MAX-1:0] sh_q;
  logic [3:0]  dat_q;
  logic [16:0] rnd_q;
  logic [9:0]  lfsr_q, lfsr_nx;
  logic        start_q, done_q, err_q;
  logic [Y-1:0]   pt_q;
  logic [127:0]   tag_q;

  // Left-justify every operand so its MSB leaves first
  // and short operands trail with zeros.
  assign par[3] = MAX'(key)   << (MAX - K);
  assign par[2] = MAX'(nonce) << (MAX - 128);
  assign par[1] = MAX'(ad)    << (MAX - L);
  assign par[0] = MAX'(ct)    << (MAX - Y);

  // Galois LFSR, x^10 + x^7 + 1
  assign lfsr_nx = {1'b0, lfsr_q[9:1]}
                 ^ (lfsr_q[0] ? 10'h240 : 10'h000);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    done_d  = 1'b0;
    err_set = 1'b0;
    unique case (state_q)
      S_IDLE:
        if (start) begin
          state_d = S_LOAD;
          accept  = 1'b1;
        end
      S_LOAD:
        if (cnt_q == CW'(MAX - 1)) state_d = S_START;
      S_START:
        if (cnt_q == CW'(START_CYC - 1)) state_d = S_WAIT;
      S_WAIT:
        if (decryption_readyxSI) begin
          state_d = S_GAP;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          state_d = S_IDLE;
          err_set = 1'b1;
        end
      S_GAP:
        if (cnt_q == CW'(GAP_CYC - 1)) state_d = S_READ;
      S_READ:
        if (cnt_q == CW'(MAX - 1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      default: state_d = S_IDLE;
    endcase
    cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;
    tmo_d = (state_q == S_WAIT && state_d == S_WAIT)
          ? tmo_q + 1'b1 : '0;
    shift = (state_q == S_LOAD) && (state_d == S_LOAD);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tmo_q   <= '0;
      sh_q    <= '0;
      dat_q   <= '0;
      rnd_q   <= '0;
      lfsr_q  <= SEED;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      pt_q    <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      done_q  <= done_d;
      start_q <= (state_d == S_START);
      if (accept) err_q <= 1'b0;
      else if (err_set) err_q <= 1'b1;
      // Outputs are registered one cycle ahead: the accept
      // edge presents bit 0, each LOAD edge the next bit.
      if (accept) begin
        for (int b = 0; b < 4; b++) begin
          dat_q[b] <= par[b][MAX-1];
          sh_q[b]  <= par[b] << 1;
        end
      end else if (shift) begin
        for (int b = 0; b < 4; b++) begin
          dat_q[b] <= sh_q[b][MAX-1];
          sh_q[b]  <= sh_q[b] << 1;
        end
      end else begin
        dat_q <= '0;
      end
      if (accept || shift) begin
        rnd_q  <= {lfsr_q, lfsr_q[9:3]};
        lfsr_q <= lfsr_nx;
      end else begin
        rnd_q  <= '0;
      end
      // Right-shift capture: after the run, sample i sits in bit i.
      if (state_q == S_READ) begin
        if (cnt_q < CW'(Y))
          pt_q <= {plain_textxSI, pt_q[Y-1:1]};
        if (cnt_q < CW'(128))
          tag_q <= {tagxSI, tag_q[127:1]};
      end
    end
  end

  assign keyxSO              = {rnd_q[7:6], dat_q[3]};
  assign noncexSO            = {rnd_q[1:0], dat_q[2]};
  assign associated_dataxSO  = {rnd_q[5:4], dat_q[1]};
  assign cipher_textxSO      = {rnd_q[3:2], dat_q[0]};
  assign r_64xSO             = rnd_q[14:8];
  assign r_128xSO            = rnd_q[16];
  assign r_ptxSO             = rnd_q[15];
  assign decryption_startxSO = start_q;
  assign pt                  = pt_q;
  assign tag                 = tag_q;
  assign busy                = (state_q != S_IDLE);
  assign done                = done_q;
  assign error               = err_q;

endmodule

// File: tb/tb_ascon_serial_host.sv
// Testbench for ascon_serial_host with a behavioural core stub.
// Table-driven vectors plus reset, timeout and ignored-event sequences.
module tb_ascon_serial_host;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] key;
  logic [127:0] nonce;
  logic [39:0]  ad;
  logic [79:0]  ct;
  logic         start;
  logic [2:0]   keyxSO, noncexSO, associated_dataxSO, cipher_textxSO;
  logic         decryption_startxSO;
  logic [6:0]   r_64xSO;
  logic         r_128xSO, r_ptxSO;
  logic         plain_textxSI, tagxSI, decryption_readyxSI;
  logic [79:0]  pt;
  logic [127:0] tag;
  logic         busy, done, error;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ascon_serial_host dut (
    .clk                 (clk),
    .rst                 (rst),
    .key                 (key),
    .nonce               (nonce),
    .ad                  (ad),
    .ct                  (ct),
    .start               (start),
    .keyxSO              (keyxSO),
    .noncexSO            (noncexSO),
    .associated_dataxSO  (associated_dataxSO),
    .cipher_textxSO      (cipher_textxSO),
    .decryption_startxSO (decryption_startxSO),
    .r_64xSO             (r_64xSO),
    .r_128xSO            (r_128xSO),
    .r_ptxSO             (r_ptxSO),
    .plain_textxSI       (plain_textxSI),
    .tagxSI              (tagxSI),
    .decryption_readyxSI (decryption_readyxSI),
    .pt                  (pt),
    .tag                 (tag),
    .busy                (busy),
    .done                (done),
    .error               (error)
  );

  typedef struct {
    logic [127:0] key;
    logic [127:0] nonce;
    logic [39:0]  ad;
    logic [79:0]  ct;
    logic [79:0]  pt;
    logic [127:0] tag;
    int           dly;
  } vec_t;

  vec_t tbl[4];

  function automatic logic [127:0] r128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [21:0] ser_all();
    return {keyxSO, noncexSO, associated_dataxSO, cipher_textxSO,
            decryption_startxSO, r_64xSO, r_128xSO, r_ptxSO};
  endfunction

  function automatic logic [16:0] rnd_all();
    return {r_128xSO, r_ptxSO, r_64xSO, keyxSO[2:1],
            associated_dataxSO[2:1], cipher_textxSO[2:1],
            noncexSO[2:1]};
  endfunction

  task automatic scramble();
    key   = r128();
    nonce = r128();
    ad    = 40'(r128());
    ct    = 80'(r128());
  endtask

  // Drive one request and stay in lockstep with the DUT:
  // sample serial load, check the start pulse, then act as the
  // core serving pt/tag bits LSB-first after the gap.
  task automatic do_op(input vec_t v);
    logic [127:0] sk, sn, sa, sc;
    bit rnd_ok, busy_ok;
    sk = '0; sn = '0; sa = '0; sc = '0;
    rnd_ok = 1; busy_ok = 1;
    @(negedge clk);
    key = v.key; nonce = v.nonce; ad = v.ad; ct = v.ct;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    scramble();
    chk("err_clr", 128'(error), 128'(0));
    for (int i = 0; i < 128; i++) begin
      sk = {sk[126:0], keyxSO[0]};
      sn = {sn[126:0], noncexSO[0]};
      sa = {sa[126:0], associated_dataxSO[0]};
      sc = {sc[126:0], cipher_textxSO[0]};
      if (rnd_all() == 17'h0) rnd_ok = 0;
      if (!busy) busy_ok = 0;
      if (i == 20) decryption_readyxSI = 1'b1;
      if (i == 23) decryption_readyxSI = 1'b0;
      @(negedge clk);
    end
    chk("load_key", sk, v.key);
    chk("load_nonce", sn, v.nonce);
    chk("load_ad", sa, {v.ad, 88'h0});
    chk("load_ct", sc, {v.ct, 48'h0});
    chk("rnd_live", 128'(rnd_ok), 128'(1));
    for (int j = 0; j < 3; j++) begin
      chk("start_hi", 128'(ser_all()), 128'(22'h1 << 9));
      @(negedge clk);
    end
    chk("start_lo", 128'(ser_all()), 128'(0));
    repeat (v.dly) @(negedge clk);
    decryption_readyxSI = 1'b1;
    @(negedge clk);
    decryption_readyxSI = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 128; i++) begin
      plain_textxSI = (i < 80) ? v.pt[i] : 1'($urandom);
      tagxSI = v.tag[i];
      if (i == 10) start = 1'b1;
      if (i == 11) start = 1'b0;
      if (!busy || done) busy_ok = 0;
      @(negedge clk);
    end
    chk("busy_run", 128'(busy_ok), 128'(1));
    chk("done_hi", 128'({done, busy}), 128'(2'b10));
    chk("pt", 128'(pt), 128'(v.pt));
    chk("tag", tag, v.tag);
    @(negedge clk);
    chk("done_lo", 128'({done, busy}), 128'(0));
    chk("idle_ser", 128'(ser_all()), 128'(0));
  endtask

  initial begin
    int n;
    tbl[0].key   = 128'h2db083053e848cefa30007336c47a5a1;
    tbl[0].nonce = 128'h3f3607dbce3503ba84f5843d623de056;
    tbl[0].ad    = 40'h4153434f4e;
    tbl[0].ct    = 80'h87a59a2ea49b233259e3;
    tbl[0].pt    = 80'h6173636f6e2d70743031;
    tbl[0].tag   = 128'hd3a1f50e7c2b9948a6e01f3c55b7e902;
    tbl[0].dly   = 0;
    for (int t = 1; t < 4; t++) begin
      tbl[t].key   = r128();
      tbl[t].nonce = r128();
      tbl[t].ad    = 40'(r128());
      tbl[t].ct    = 80'(r128());
      tbl[t].pt    = 80'(r128());
      tbl[t].tag   = r128();
      tbl[t].dly   = int'($urandom_range(1, 6));
    end

    rst = 1'b0; start = 1'b0;
    key = '0; nonce = '0; ad = '0; ct = '0;
    plain_textxSI = 1'b0; tagxSI = 1'b0;
    decryption_readyxSI = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ser", 128'(ser_all()), 128'(0));
    chk("rst_flags", 128'({busy, done, error}), 128'(0));
    chk("rst_pt", 128'(pt), 128'(0));
    chk("rst_tag", tag, 128'(0));
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int t = 0; t < 4; t++) do_op(tbl[t]);

    // Timeout: core never answers.
    @(negedge clk);
    key = tbl[0].key; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (131) @(negedge clk);
    chk("wait_busy", 128'(busy), 128'(1));
    n = 0;
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_cycles", 128'(n), 128'(4096));
    chk("tmo_flags", 128'({busy, error}), 128'(2'b01));
    decryption_readyxSI = 1'b1;
    repeat (3) @(negedge clk);
    decryption_readyxSI = 1'b0;
    chk("err_sticky", 128'({busy, error}), 128'(2'b01));
    do_op(tbl[1]);

    // Asynchronous reset in the middle of LOAD.
    @(negedge clk);
    key = tbl[2].key; nonce = tbl[2].nonce;
    ad = tbl[2].ad; ct = tbl[2].ct;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_rst_busy", 128'(busy), 128'(1));
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_ser", 128'(ser_all()), 128'(0));
    chk("mid_rst_flags", 128'({busy, done, error}), 128'(0));
    chk("mid_rst_pt", 128'(pt), 128'(0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", 128'({busy, ser_all()}), 128'(0));
    do_op(tbl[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
